// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and defaults for the HI/LO multiply/divide unit
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      FIN  = 2'b11
   } state_t;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } mode_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add multiply or restoring divide iteration
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             mode,
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] shreg,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   acc_nxt,
   output logic [WIDTH-1:0] shreg_nxt
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH+1:0] trial;

   // Divide keeps the partial remainder in acc; the borrow out of trial decides the quotient bit.
   always_comb begin
      addend    = shreg[0] ? b : '0;
      sum       = {1'b0, acc[WIDTH-1:0]} + {1'b0, addend};
      trial     = {acc, shreg[WIDTH-1]} - {2'b00, b};
      acc_nxt   = {1'b0, sum[WIDTH:1]};
      shreg_nxt = {sum[0], shreg[WIDTH-1:1]};
      if (mode == MODE_DIV) begin
         if (!trial[WIDTH+1]) begin
            acc_nxt   = trial[WIDTH:0];
            shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt   = {acc[WIDTH-1:0], shreg[WIDTH-1]};
            shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULTU/DIVU sequencer with HI/LO commit and pipeline stall
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_req,
   input  logic             flush,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = $clog2(WIDTH);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   acc, acc_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt, bsh;
   logic             accept, commit, mode;

   assign busy  = (state == MUL) || (state == DIV);
   assign done  = (state == FIN);
   assign stall = busy & (start | rd_req);
   assign mode  = (state == DIV) ? MODE_DIV : MODE_MUL;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode      (mode),
      .acc       (acc),
      .shreg     (shreg),
      .b         (bsh),
      .acc_nxt   (acc_nxt),
      .shreg_nxt (shreg_nxt)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE, FIN: begin
            state_nxt = IDLE;
            if (start && !flush) begin
               if (op == OP_MULTU) begin
                  state_nxt = MUL;
                  accept    = 1'b1;
               end else if (op == OP_DIVU) begin
                  state_nxt = DIV;
                  accept    = 1'b1;
               end
            end
         end
         MUL, DIV: begin
            if (flush) begin
               state_nxt = IDLE;
            end else if (cnt == CW'(WIDTH - 1)) begin
               state_nxt = FIN;
               commit    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // hi/lo are written only from the final step, so partial work never leaks architecturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         shreg <= '0;
         bsh   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            acc   <= '0;
            shreg <= a;
            bsh   <= b;
            cnt   <= '0;
         end else if (busy && !flush) begin
            acc   <= acc_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt + 1'b1;
         end
         if (commit) begin
            hi <= acc_nxt[WIDTH-1:0];
            lo <= shreg_nxt;
         end
      end
   end

endmodule
